// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and APB-side signals of the two-requester APB master
interface apb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1, wr0, wr1, done0, done1, err;
  logic                  psel, penable, pwrite, pready, pslverr;
  logic [ADDR_WIDTH-1:0] addr0, addr1, paddr;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, rdata, pwdata, prdata;
  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
    output done0, done1, rdata, err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
    input  done0, done1, rdata, err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin two-requester APB master with bounded pready timeout
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic                 pclk,
  input logic                 preset,
  apb_master_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state, state_n;
  logic                  last, last_n, gnt, gnt_n, psel_n, penable_n, pwrite_n, err_n, done0_n, done1_n;
  logic                  arb, both, tmo, fin;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic [DATA_WIDTH-1:0] pwdata_n, rdata_n;
  // the done cycle is a forced bubble: nothing is granted while a done pulse is out
  assign arb  = !bus.done0 && !bus.done1 && (bus.req0 || bus.req1);
  assign both = bus.req0 && bus.req1;
  assign tmo  = cnt == CW'(TIMEOUT - 1);
  assign fin  = bus.pready || tmo;
  always_comb begin
    state_n   = state;
    last_n    = last;
    gnt_n     = gnt;
    cnt_n     = cnt;
    psel_n    = bus.psel;
    penable_n = bus.penable;
    pwrite_n  = bus.pwrite;
    paddr_n   = bus.paddr;
    pwdata_n  = bus.pwdata;
    rdata_n   = bus.rdata;
    err_n     = bus.err;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
    case (state)
      IDLE: if (arb) begin
        gnt_n     = both ? ~last : bus.req1;
        last_n    = both ? gnt_n : last;
        pwrite_n  = gnt_n ? bus.wr1 : bus.wr0;
        paddr_n   = gnt_n ? bus.addr1 : bus.addr0;
        pwdata_n  = gnt_n ? bus.wdata1 : bus.wdata0;
        psel_n    = 1'b1;
        penable_n = 1'b0;
        state_n   = SETUP;
      end
      SETUP: begin
        penable_n = 1'b1;
        cnt_n     = '0;
        state_n   = ACCESS;
      end
      ACCESS: if (fin) begin
        rdata_n   = (bus.pready && !bus.pwrite) ? bus.prdata : '0;
        err_n     = bus.pready ? bus.pslverr : 1'b1;
        done0_n   = !gnt;
        done1_n   = gnt;
        psel_n    = 1'b0;
        penable_n = 1'b0;
        state_n   = IDLE;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      last        <= 1'b1;
      gnt         <= 1'b0;
      cnt         <= '0;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
      bus.rdata   <= '0;
      bus.err     <= 1'b0;
      bus.done0   <= 1'b0;
      bus.done1   <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      gnt         <= gnt_n;
      cnt         <= cnt_n;
      bus.psel    <= psel_n;
      bus.penable <= penable_n;
      bus.pwrite  <= pwrite_n;
      bus.paddr   <= paddr_n;
      bus.pwdata  <= pwdata_n;
      bus.rdata   <= rdata_n;
      bus.err     <= err_n;
      bus.done0   <= done0_n;
      bus.done1   <= done1_n;
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench with a table-driven APB slave and per-requester expectation queues
module tb_apb_master_arbiter;
  localparam int AW = 10, DW = 32, TO = 16;
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          err;
    int            acc;
    int            done_cyc;
  } exp_t;
  logic pclk = 1'b0, preset = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  exp_t q0[$], q1[$];
  int gnt_log[$];
  int wait_tab[1024];
  bit err_tab[1024];
  logic [DW-1:0] slv_mem[1024], ref_mem[1024];
  apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .bus(bus)
  );
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // expected outcome from the slave tables: wait states beyond the limit mean an aborted transfer
  function automatic void push_exp(input int id, input logic wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input bit timed);
    exp_t e;
    bit tmo;
    tmo = wait_tab[a] >= TO;
    e.wr = wr;
    e.addr = a;
    e.wdata = d;
    e.acc = tmo ? TO : wait_tab[a] + 1;
    e.err = tmo ? 1'b1 : err_tab[a];
    e.rdata = (tmo || wr) ? '0 : ref_mem[a];
    if (!tmo && wr && !err_tab[a]) ref_mem[a] = d;
    e.done_cyc = timed ? cyc + 2 + e.acc : -1;
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endfunction
  task automatic drive(input int id, input logic r, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (id == 0) begin
      bus.req0 = r; bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask
  task automatic do_req(input int id, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit timed);
    int n;
    push_exp(id, wr, a, d, timed);
    drive(id, 1'b1, wr, a, d);
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!(id != 0 ? bus.done1 : bus.done0) && n < 100);
    chk("req_wait", n < 100, 1);
    drive(id, 1'b0, 1'($urandom), AW'($urandom), $urandom);
    @(posedge pclk); #1;
  endtask
  task automatic rnd_req(input int id);
    int g;
    logic [AW-1:0] a;
    g = $urandom_range(0, 3);
    repeat (g) begin
      @(posedge pclk); #1;
    end
    a = {id[0], 9'($urandom)};
    do_req(id, 1'($urandom), a, $urandom, 1'b0);
  endtask
  // slave: completes after wait_tab[paddr] wait states, junk on pready/pslverr outside ACCESS
  initial begin
    int acnt;
    bit rdy;
    acnt = 0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(posedge pclk); #1;
      if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
        rdy = acnt == wait_tab[bus.paddr];
        bus.pready = rdy;
        bus.pslverr = rdy ? err_tab[bus.paddr] : 1'($urandom);
        bus.prdata = (rdy && !bus.pwrite) ? slv_mem[bus.paddr] : $urandom;
        if (rdy && bus.pwrite && !err_tab[bus.paddr]) slv_mem[bus.paddr] = bus.pwdata;
        acnt++;
      end else begin
        acnt = 0;
        bus.pready = 1'($urandom);
        bus.pslverr = 1'($urandom);
        bus.prdata = $urandom;
      end
    end
  end
  // monitor: identifies the grant at SETUP, checks hold and completion against the queues
  initial begin
    int cur, acc, id;
    bit prev_done;
    logic [AW+DW:0] held;
    exp_t e;
    cur = -1; acc = 0; prev_done = 1'b0; held = '0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        q0.delete(); q1.delete();
        cur = -1; acc = 0; prev_done = 1'b0;
      end else begin
        if (bus.psel && !bus.penable) begin
          chk("bubble_before_setup", prev_done, 0);
          if (q0.size() > 0 && q0[0].addr == bus.paddr && q0[0].wr == bus.pwrite && q0[0].wdata == bus.pwdata) cur = 0;
          else if (q1.size() > 0 && q1[0].addr == bus.paddr && q1[0].wr == bus.pwrite && q1[0].wdata == bus.pwdata) cur = 1;
          else cur = -1;
          chk("setup_match", cur >= 0, 1);
          held = {bus.paddr, bus.pwrite, bus.pwdata};
          acc = 0;
        end
        if (bus.psel && bus.penable) begin
          chk("access_hold", {bus.paddr, bus.pwrite, bus.pwdata}, held);
          acc++;
        end
        if (bus.done0 || bus.done1) begin
          id = bus.done1 ? 1 : 0;
          chk("done_exclusive", bus.done0 & bus.done1, 0);
          chk("done_pulse", prev_done, 0);
          chk("done_id", id, cur);
          chk("psel_at_done", {bus.psel, bus.penable}, 0);
          if ((id != 0 ? q1.size() : q0.size()) == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: actual=done%0d required=no done (cycle %0d)", id, cyc);
          end else begin
            if (id != 0) e = q1.pop_front(); else e = q0.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("err", bus.err, e.err);
            chk("access_cycles", acc, e.acc);
            if (e.done_cyc >= 0) chk("done_cycle", cyc, e.done_cyc);
          end
          gnt_log.push_back(id);
          cur = -1;
        end
        prev_done = bus.done0 || bus.done1;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end
  initial begin
    int n;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    for (int i = 0; i < 1024; i++) begin
      wait_tab[i] = $urandom_range(0, 3);
      err_tab[i] = $urandom_range(0, 3) == 0;
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_done0", bus.done0, 0);
    chk("rst_done1", bus.done1, 0);
    @(posedge pclk); #1;
    wait_tab[10'h155] = 0; err_tab[10'h155] = 1'b0;
    do_req(0, 1'b1, 10'h155, 32'hDEADBEEF, 1'b1);
    wait_tab[10'h155] = 3;
    do_req(1, 1'b0, 10'h155, 32'h0, 1'b1);
    gnt_log.delete();
    fork
      begin do_req(0, 1'b1, 10'h021, $urandom, 1'b0); do_req(0, 1'b0, 10'h022, $urandom, 1'b0); end
      begin do_req(1, 1'b1, 10'h221, $urandom, 1'b0); do_req(1, 1'b0, 10'h222, $urandom, 1'b0); end
    join
    chk("grant_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("grant_order", gnt_log[i], exp_g[i]);
    wait_tab[10'h033] = 0; err_tab[10'h033] = 1'b1;
    wait_tab[10'h034] = 0; err_tab[10'h034] = 1'b0;
    do_req(0, 1'b1, 10'h033, $urandom, 1'b1);
    do_req(1, 1'b0, 10'h034, $urandom, 1'b1);
    wait_tab[10'h0AA] = 1000;
    do_req(0, 1'b0, 10'h0AA, $urandom, 1'b1);
    push_exp(0, 1'b0, 10'h0AA, 32'h0, 1'b0);
    drive(0, 1'b1, 1'b0, 10'h0AA, 32'h0);
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (!(bus.psel && bus.penable) && n < 20);
    chk("access_wait", n < 20, 1);
    repeat (3) begin
      @(posedge pclk); #1;
    end
    preset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("midrst_psel", bus.psel, 0);
    chk("midrst_penable", bus.penable, 0);
    chk("midrst_done", {bus.done0, bus.done1}, 0);
    @(negedge pclk);
    chk("midrst_no_done", {bus.done0, bus.done1}, 0);
    @(posedge pclk); #1;
    gnt_log.delete();
    fork
      do_req(0, 1'b1, 10'h0B0, $urandom, 1'b0);
      do_req(1, 1'b1, 10'h2B0, $urandom, 1'b0);
    join
    chk("grant_after_reset_count", gnt_log.size(), 2);
    if (gnt_log.size() > 0) chk("grant_after_reset", gnt_log[0], 0);
    fork
      begin for (int i = 0; i < 20; i++) rnd_req(0); end
      begin for (int j = 0; j < 20; j++) rnd_req(1); end
    join
    repeat (5) @(posedge pclk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
